apb_requester: RTL and testbench
================================

Name: apb_requester

Overview:
- APB master for the peripheral register block. Accepts single read or write commands on a valid/ready command port and runs each one as one APB transfer: SETUP phase, then ACCESS phase.
- Waits for pready, then returns read data and status on a one-cycle response strobe.
- Drives the APB slave memory/register blocks in the WDT subsystem, and is the stimulus-side counterpart the passive BFM monitors.

Parameters:
- ADDR_W, 32, width of cmd_addr and paddr.
- DATA_W, 32, width of write/read data.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort; used only with APB_TIMEOUT_EN; must be >= 2.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- prstn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  requester idle, can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse, transfer complete.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  transfer aborted by timeout; always 0 without APB_TIMEOUT_EN.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready from slave.

Behaviour:
- Reset:
  - Sampled only at the pclk rising edge while prstn=0.
  - Next state is IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0; timeout counter = 0.
  - cmd_ready = 0 while prstn=0.
- cmd_ready = (state==IDLE) && prstn; combinational from state.
- Command acceptance: cmd_valid && cmd_ready at edge N.
  - cmd_write, cmd_addr and cmd_wdata are captured into pwrite/paddr/pwdata.
  - State goes to SETUP.
- States:
  - IDLE: psel=0, penable=0. Go to SETUP on acceptance.
  - SETUP: one cycle exactly, psel=1, penable=0. Unconditionally go to ACCESS.
  - ACCESS: psel=1, penable=1. Stay while pready=0. On an edge with pready=1, go to IDLE: psel and penable drop to 0, rsp_valid=1 for one cycle, rsp_rdata = prdata if read else 0, rsp_err=0.
- Minimum latency: acceptance edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid high in cycle N+3.
- Throughput: cmd_ready is high again in the same cycle as rsp_valid, so a back-to-back command is accepted at that edge. Peak rate is one transfer per 3 cycles. psel always drops for at least one cycle between transfers; no SETUP-from-ACCESS chaining.
- Stability:
  - pwrite, paddr and pwdata stay constant from SETUP through the final ACCESS cycle.
  - paddr and pwdata hold their last value in IDLE; pwrite holds its last value.
- cmd_* changes while not in IDLE are ignored.
- pready is ignored outside ACCESS. pready=1 during SETUP does not shorten the transfer.
- rsp_rdata and rsp_err hold their values until the next response. rsp_valid is not backpressured.
- Reset mid-transfer, in SETUP or ACCESS: the transfer is abandoned with no response pulse. psel and penable are 0 in the cycle after the reset edge.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to ACCESS and increments on each ACCESS edge with pready=0.
  - When it reaches TIMEOUT_CYCLES-1 with pready still 0, the FSM returns to IDLE: psel and penable drop, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - pready=1 on that same edge takes priority: normal completion with rsp_err=0.
- Without the macro: no counter logic; ACCESS waits indefinitely; rsp_err tied to 0.

Test Plan:
- Reset: hold prstn=0 for 3 edges with cmd_valid=1 -> psel=penable=rsp_valid=0, cmd_ready=0, paddr=0; release -> cmd_ready=1 on the next cycle.
- Zero-wait write: cmd write addr=0x10, wdata=0xDEADBEEF, pready tied 1 -> psel=1/penable=0 in cycle N+1, penable=1 in cycle N+2, rsp_valid=1 with rsp_err=0 in cycle N+3; a read of 0x10 from the slave memory model returns 0xDEADBEEF.
- Wait states: read addr=0x20 with pready low for 4 ACCESS cycles, then prdata=0x12345678 and pready=1 -> exactly 5 ACCESS cycles, paddr stable throughout, rsp_rdata=0x12345678.
- Back-to-back: write 0x4 then read 0x4 with cmd_valid held high -> second command accepted in the rsp_valid cycle, one psel=0 cycle between transfers, read returns the written value.
- Reset mid-ACCESS: assert prstn=0 during a stalled ACCESS -> no rsp_valid, psel=penable=0 after the edge; the next command completes normally.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16, pready stuck 0 -> rsp_valid with rsp_err=1 and rsp_rdata=0 after 16 ACCESS cycles; a variant raising pready on the 16th ACCESS edge -> rsp_err=0.

Source files
------------

// File: rtl/apb_requester.sv
// apb_requester: single-transfer APB master (SETUP then ACCESS) behind a valid/ready command port.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES cycles.
module apb_requester #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_done;
  logic              w_timeout;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_requester: TIMEOUT_CYCLES must be >= 2");
  end

  assign cmd_ready = (r_state == ST_IDLE) && prstn;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_done    = (r_state == ST_ACCESS) && pready;

  // NOTE: state and data registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (!prstn) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_done || w_timeout) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Command capture and response register; pready completion wins over a same-edge timeout.
  always_ff @(posedge pclk) begin
    if (!prstn) begin
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
      if (w_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= r_pwrite ? '0 : prdata;
      end else if (w_timeout) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_err;

  assign w_timeout = (r_state == ST_ACCESS) && !pready &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // r_cnt counts stalled ACCESS edges; it restarts during SETUP for each transfer.
  always_ff @(posedge pclk) begin
    if (!prstn) begin
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == ST_SETUP)                 r_cnt <= '0;
      else if (r_state == ST_ACCESS && !pready) r_cnt <= r_cnt + 1'b1;
      if (w_done)         r_rsp_err <= 1'b0;
      else if (w_timeout) r_rsp_err <= 1'b1;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  assign psel      = (r_state != ST_IDLE);
  assign penable   = (r_state == ST_ACCESS);
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed vector table plus hand-written reset, back-to-back and stall sequences.
// A small APB slave memory with programmable wait states answers the requester.
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        prstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  int n_vec = 0;
  int n_err = 0;

  // Slave model: pready rises once wait_n stalled ACCESS cycles have elapsed, unless stall is set.
  logic [31:0] mem [256];
  int          wait_n = 0;
  bit          stall  = 1'b0;
  int          acc_cnt = 0;

  apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .prstn(prstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  assign pready = !stall && (acc_cnt >= wait_n);
  assign prdata = mem[paddr[9:2]];

  always @(posedge pclk) begin
    acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
    if (psel && penable && pready && pwrite) mem[paddr[9:2]] <= pwdata;
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command from IDLE and checks phases, ACCESS length, stability and the response.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_acc, input logic [31:0] exp_rdata, input logic exp_err);
    int acc;
    bit got;
    bit stable;
    @(negedge pclk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
    check("setup_phase", 64'({psel, penable}), 64'b10);
    acc = 0; got = 1'b0; stable = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge pclk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (psel && penable) acc++;
      else stable = 1'b0;
      if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) stable = 1'b0;
    end
    check("rsp_seen", 64'(got), 64'd1);
    if (got) begin
      check("access_cycles", 64'(acc), 64'(exp_acc));
      check("access_stable", 64'(stable), 64'd1);
      check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      check("rsp_err", 64'(rsp_err), 64'(exp_err));
      check("psel_drop", 64'({psel, penable}), 64'b00);
      check("cmd_ready_rsp", 64'(cmd_ready), 64'd1);
      @(negedge pclk);
      check("rsp_one_pulse", 64'(rsp_valid), 64'd0);
      check("rsp_rdata_hold", 64'(rsp_rdata), 64'(exp_rdata));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[32'h20 >> 2] = 32'h1234_5678;

    vecs[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[1] = '{1'b0, 32'h10, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h20, 32'h0,         4, 32'h1234_5678};
    vecs[3] = '{1'b1, 32'h4,  32'hA5A5_5A5A, 2, 32'h0};
    vecs[4] = '{1'b0, 32'h4,  32'h0,         1, 32'hA5A5_5A5A};
    vecs[5] = '{1'b0, 32'h8,  32'h0,         3, 32'hC0DE_0002};

    // Reset held for three edges with a command pending.
    prstn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_psel_penable", 64'({psel, penable}), 64'b00);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    prstn = 1'b1; cmd_valid = 1'b0;
    @(negedge pclk);
    check("rst_release_ready", 64'(cmd_ready), 64'd1);

    foreach (vecs[i]) begin
      wait_n = vecs[i].waits;
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits + 1,
              vecs[i].exp_rdata, 1'b0);
    end

    // Back-to-back: cmd_valid held, second command changes while the first is busy.
    wait_n = 0;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h0BAD_F00D;
    @(negedge pclk);
    cmd_write = 1'b0; cmd_wdata = 32'h1111_1111;
    check("b2b_setup1", 64'({psel, penable, pwrite}), 64'b101);
    @(negedge pclk);
    check("b2b_access1", 64'({psel, penable, pwrite}), 64'b111);
    check("b2b_pwdata_held", 64'(pwdata), 64'h0BAD_F00D);
    @(negedge pclk);
    check("b2b_rsp1", 64'({rsp_valid, psel, cmd_ready}), 64'b101);
    @(negedge pclk);
    cmd_valid = 1'b0;
    check("b2b_setup2", 64'({psel, penable, pwrite}), 64'b100);
    @(negedge pclk);
    check("b2b_access2", 64'({psel, penable}), 64'b11);
    @(negedge pclk);
    check("b2b_rsp2", 64'(rsp_valid), 64'd1);
    check("b2b_rdata", 64'(rsp_rdata), 64'h0BAD_F00D);

    // Reset during a stalled ACCESS abandons the transfer silently.
    stall = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    check("mid_stall_access", 64'({psel, penable}), 64'b11);
    prstn = 1'b0;
    @(negedge pclk);
    check("mid_rst_psel", 64'({psel, penable}), 64'b00);
    check("mid_rst_rsp", 64'(rsp_valid), 64'd0);
    check("mid_rst_rdata", 64'(rsp_rdata), 64'd0);
    prstn = 1'b1; stall = 1'b0;
    @(negedge pclk);
    check("mid_after_rsp", 64'(rsp_valid), 64'd0);
    run_cmd(1'b0, 32'h20, 32'h0, 1, 32'h1234_5678, 1'b0);

    // pready arriving on the 16th ACCESS edge completes normally in either build.
    wait_n = 15;
    run_cmd(1'b0, 32'h10, 32'h0, 16, 32'hDEAD_BEEF, 1'b0);

`ifdef APB_TIMEOUT_EN
    wait_n = 0; stall = 1'b1;
    run_cmd(1'b0, 32'h20, 32'h0, 16, 32'h0, 1'b1);
    stall = 1'b0;
    run_cmd(1'b0, 32'h20, 32'h0, 1, 32'h1234_5678, 1'b0);
`else
    wait_n = 30;
    run_cmd(1'b0, 32'h20, 32'h0, 31, 32'h1234_5678, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
